// File: rtl/spi_mem_cmd_ctrl.sv
// SPI command sequencer: parses CMD/ADDR/LEN bursts from the RX stream and drives a BRAM port.
// Optional user port and alternating-priority arbiter are enabled with SPI_MEM_USER_PORT_EN.
module spi_mem_cmd_ctrl #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  usr_req,
  input  logic                  usr_we,
  input  logic [ADDR_WIDTH-1:0] usr_addr,
  input  logic [DATA_WIDTH-1:0] usr_wdata,
  output logic                  usr_gnt,
  output logic                  usr_rvalid,
  output logic [DATA_WIDTH-1:0] usr_rdata,
  output logic                  busy
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ADDR  = 3'd1;
  localparam logic [2:0] S_LEN   = 3'd2;
  localparam logic [2:0] S_WDATA = 3'd3;
  localparam logic [2:0] S_RDATA = 3'd4;

  localparam logic [DATA_WIDTH-1:0] CMD_WR = DATA_WIDTH'(8'h01);
  localparam logic [DATA_WIDTH-1:0] CMD_RD = DATA_WIDTH'(8'h02);

  logic [2:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [7:0]            cnt_q, cnt_d;
  logic                  is_wr_q, is_wr_d;
  logic                  rd_pend_q, rd_pend_d;
  logic                  txv_q, txv_d;
  logic [DATA_WIDTH-1:0] txd_q, txd_d;
  logic                  spi_req, spi_gnt, usr_gnt_w;
  logic                  rx_fire, tx_fire;

  // Read data is forwarded straight from the BRAM in the cycle after the grant,
  // and only parked in txd_q when the TX FIFO stalls.
  assign tx_valid = txv_q | rd_pend_q;
  assign tx_data  = rd_pend_q ? mem_rdata : txd_q;
  assign tx_fire  = tx_valid & tx_ready;

  assign spi_req  = (state_q == S_WDATA) ? rx_valid
                  : ((state_q == S_RDATA) & ~rd_pend_q & ~txv_q);
  assign rx_ready = (state_q == S_WDATA) ? spi_gnt : 1'b1;
  assign rx_fire  = rx_valid & rx_ready;
  assign busy     = (state_q != S_IDLE);
  assign usr_gnt  = usr_gnt_w;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    is_wr_d   = is_wr_q;
    rd_pend_d = 1'b0;
    txv_d     = txv_q;
    txd_d     = txd_q;
    case (state_q)
      S_IDLE: if (rx_fire && (rx_data == CMD_WR || rx_data == CMD_RD)) begin
        state_d = S_ADDR;
        is_wr_d = (rx_data == CMD_WR);
      end
      S_ADDR: if (rx_fire) begin
        ptr_d   = ADDR_WIDTH'(rx_data);
        state_d = S_LEN;
      end
      S_LEN: if (rx_fire) begin
        cnt_d   = 8'(rx_data);
        state_d = is_wr_q ? S_WDATA : S_RDATA;
      end
      S_WDATA: if (spi_gnt) begin
        ptr_d = ptr_q + 1'b1;
        cnt_d = cnt_q - 8'd1;
        if (cnt_q == 8'd0) state_d = S_IDLE;
      end
      S_RDATA: begin
        if (spi_gnt) begin
          ptr_d     = ptr_q + 1'b1;
          rd_pend_d = 1'b1;
        end
        if (rd_pend_q) begin
          txd_d = mem_rdata;
          txv_d = ~tx_ready;
        end else if (tx_fire) begin
          txv_d = 1'b0;
        end
        if (tx_fire) begin
          cnt_d = cnt_q - 8'd1;
          if (cnt_q == 8'd0) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      ptr_q     <= '0;
      cnt_q     <= '0;
      is_wr_q   <= 1'b0;
      rd_pend_q <= 1'b0;
      txv_q     <= 1'b0;
      txd_q     <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      is_wr_q   <= is_wr_d;
      rd_pend_q <= rd_pend_d;
      txv_q     <= txv_d;
      txd_q     <= txd_d;
    end
  end

`ifdef SPI_MEM_USER_PORT_EN
  logic last_usr_q, last_usr_d;
  logic usr_rv_q;

  // last_usr_q only moves on contested cycles; the loser of the last contest wins the next.
  assign usr_gnt_w  = usr_req & (~spi_req | ~last_usr_q);
  assign spi_gnt    = spi_req & (~usr_req | last_usr_q);
  assign last_usr_d = (spi_req & usr_req) ? usr_gnt_w : last_usr_q;

  assign mem_addr   = spi_gnt ? ptr_q   : usr_addr;
  assign mem_wdata  = spi_gnt ? rx_data : usr_wdata;
  assign mem_we     = spi_gnt ? (state_q == S_WDATA) : (usr_gnt_w & usr_we);
  assign usr_rvalid = usr_rv_q;
  assign usr_rdata  = usr_rv_q ? mem_rdata : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_usr_q <= 1'b1;
      usr_rv_q   <= 1'b0;
    end else begin
      last_usr_q <= last_usr_d;
      usr_rv_q   <= usr_gnt_w & ~usr_we;
    end
  end
`else
  logic unused_usr;

  assign spi_gnt    = spi_req;
  assign usr_gnt_w  = 1'b0;
  assign mem_addr   = ptr_q;
  assign mem_wdata  = rx_data;
  assign mem_we     = spi_gnt & (state_q == S_WDATA);
  assign usr_rvalid = 1'b0;
  assign usr_rdata  = '0;
  assign unused_usr = ^{usr_req, usr_we, usr_addr, usr_wdata};
`endif

endmodule

// File: tb/tb_spi_mem_cmd_ctrl.sv
// Directed bench for spi_mem_cmd_ctrl with a behavioural BRAM and a TX stream recorder.
module tb_spi_mem_cmd_ctrl;
  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data, tx_data, mem_wdata, mem_rdata, usr_wdata, usr_rdata;
  logic       rx_valid, rx_ready, tx_valid, tx_ready, mem_we;
  logic [7:0] mem_addr, usr_addr;
  logic       usr_req, usr_we, usr_gnt, usr_rvalid, busy;

  spi_mem_cmd_ctrl #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .usr_req(usr_req), .usr_we(usr_we), .usr_addr(usr_addr), .usr_wdata(usr_wdata),
    .usr_gnt(usr_gnt), .usr_rvalid(usr_rvalid), .usr_rdata(usr_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int last_wait;
  int usr_gnt_seen = 0;
  int base;
  logic mem_clr;
  logic [7:0] mem [0:255];
  logic [7:0] txq [$];
  int         txt [$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
      mem_rdata <= 8'h00;
    end else begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      mem_rdata <= mem[mem_addr];
    end
  end

  always @(negedge clk) begin
    if (!rst && tx_valid && tx_ready) begin
      txq.push_back(tx_data);
      txt.push_back(cyc);
    end
    if (usr_gnt) usr_gnt_seen <= usr_gnt_seen + 1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    rx_data = b;
    rx_valid = 1'b1;
    @(negedge clk);
    while (!rx_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    last_wait = n;
    if (n >= 50) check("rx_accept_timeout", {31'd0, rx_ready}, 32'd1);
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_cmd(input logic [7:0] c, input logic [7:0] a, input logic [7:0] l);
    send_byte(c);
    send_byte(a);
    send_byte(l);
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (!busy) break;
    end
    check("idle_reached", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [7:0] exp_rd [4];
    exp_rd[0] = 8'hAA; exp_rd[1] = 8'hBB; exp_rd[2] = 8'hCC; exp_rd[3] = 8'hDD;
    rst = 1'b1; mem_clr = 1'b1;
    rx_data = 8'h00; rx_valid = 1'b0; tx_ready = 1'b1;
    usr_req = 1'b0; usr_we = 1'b0; usr_addr = 8'h00; usr_wdata = 8'h00;
    repeat (3) @(posedge clk);
    #1 mem_clr = 1'b0;
    @(negedge clk);
    check("rst_busy",       {31'd0, busy},       32'd0);
    check("rst_tx_valid",   {31'd0, tx_valid},   32'd0);
    check("rst_tx_data",    {24'd0, tx_data},    32'd0);
    check("rst_mem_we",     {31'd0, mem_we},     32'd0);
    check("rst_usr_gnt",    {31'd0, usr_gnt},    32'd0);
    check("rst_usr_rvalid", {31'd0, usr_rvalid}, 32'd0);
    check("rst_usr_rdata",  {24'd0, usr_rdata},  32'd0);
    check("rst_rx_ready",   {31'd0, rx_ready},   32'd1);
    rst = 1'b0;
    @(posedge clk); #1;

    // write 4 bytes then read them back
    send_cmd(8'h01, 8'h10, 8'h03);
    for (int i = 0; i < 4; i++) begin
      send_byte(exp_rd[i]);
      check("wr_no_stall", last_wait, 32'd0);
    end
    wait_idle();
    for (int i = 0; i < 4; i++) check("wr_mem", {24'd0, mem[8'h10 + i]}, {24'd0, exp_rd[i]});

    txq.delete(); txt.delete();
    send_cmd(8'h02, 8'h10, 8'h03);
    for (int i = 0; i < 4; i++) send_byte(8'h00);
    wait_idle();
    check("rd_count", txq.size(), 32'd4);
    for (int i = 0; i < 4; i++)
      if (i < txq.size()) check("rd_data", {24'd0, txq[i]}, {24'd0, exp_rd[i]});
    for (int i = 1; i < 4; i++)
      if (i < txt.size()) check("rd_spacing", txt[i] - txt[i-1], 32'd2);

    // wrap-around write
    send_cmd(8'h01, 8'hFE, 8'h02);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    wait_idle();
    check("wrap_FE", {24'd0, mem[8'hFE]}, 32'h11);
    check("wrap_FF", {24'd0, mem[8'hFF]}, 32'h22);
    check("wrap_00", {24'd0, mem[8'h00]}, 32'h33);

    // unknown command, then read with TX backpressure
    send_byte(8'h7F);
    @(negedge clk);
    check("unk_cmd_idle", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    tx_ready = 1'b0;
    txq.delete(); txt.delete();
    send_cmd(8'h02, 8'hFE, 8'h02);
    for (int i = 0; i < 3; i++) send_byte(8'h00);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_hold", {23'd0, tx_valid, tx_data}, 32'h111);
    end
    @(posedge clk); #1;
    tx_ready = 1'b1;
    wait_idle();
    check("bp_count", txq.size(), 32'd3);
    if (txq.size() == 3) begin
      check("bp_b0", {24'd0, txq[0]}, 32'h11);
      check("bp_b1", {24'd0, txq[1]}, 32'h22);
      check("bp_b2", {24'd0, txq[2]}, 32'h33);
    end

    // reset mid write burst
    send_cmd(8'h01, 8'h30, 8'h03);
    send_byte(8'hA1); send_byte(8'hA2);
    rst = 1'b1;
    #1;
    check("rstw_busy",     {31'd0, busy},     32'd0);
    check("rstw_rx_ready", {31'd0, rx_ready}, 32'd1);
    check("rstw_mem_we",   {31'd0, mem_we},   32'd0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    check("rstw_m30", {24'd0, mem[8'h30]}, 32'hA1);
    check("rstw_m31", {24'd0, mem[8'h31]}, 32'hA2);
    check("rstw_m32", {24'd0, mem[8'h32]}, 32'h00);
    send_cmd(8'h01, 8'h32, 8'h00);
    send_byte(8'hC3);
    wait_idle();
    check("post_rst_m32", {24'd0, mem[8'h32]}, 32'hC3);
    check("post_rst_m33", {24'd0, mem[8'h33]}, 32'h00);

    // reset while a read byte is stalled on TX
    tx_ready = 1'b0;
    send_cmd(8'h02, 8'h10, 8'h00);
    send_byte(8'h00);
    @(negedge clk);
    check("rstr_tx_valid_pre", {31'd0, tx_valid}, 32'd1);
    check("rstr_tx_data_pre",  {24'd0, tx_data},  32'hAA);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("rstr_tx_valid", {31'd0, tx_valid}, 32'd0);
    check("rstr_tx_data",  {24'd0, tx_data},  32'd0);
    check("rstr_busy",     {31'd0, busy},     32'd0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    tx_ready = 1'b1;

`ifdef SPI_MEM_USER_PORT_EN
    // contention: SPI wins first conflict, user the next
    send_cmd(8'h01, 8'h20, 8'h00);
    rx_data = 8'h77; rx_valid = 1'b1;
    usr_req = 1'b1; usr_we = 1'b1; usr_addr = 8'h40; usr_wdata = 8'h5A;
    @(negedge clk);
    check("c1_spi_gnt", {31'd0, rx_ready}, 32'd1);
    check("c1_usr_gnt", {31'd0, usr_gnt},  32'd0);
    check("c1_addr",    {24'd0, mem_addr}, 32'h20);
    @(posedge clk); #1;
    rx_valid = 1'b0;
    @(negedge clk);
    check("c1_usr_next", {31'd0, usr_gnt},  32'd1);
    check("c1_usr_addr", {24'd0, mem_addr}, 32'h40);
    @(posedge clk); #1;
    usr_req = 1'b0;
    check("c1_m20", {24'd0, mem[8'h20]}, 32'h77);
    check("c1_m40", {24'd0, mem[8'h40]}, 32'h5A);
    send_cmd(8'h01, 8'h21, 8'h01);
    rx_data = 8'h88; rx_valid = 1'b1;
    usr_req = 1'b1; usr_we = 1'b1; usr_addr = 8'h41; usr_wdata = 8'h6B;
    @(negedge clk);
    check("c2_usr_gnt", {31'd0, usr_gnt},  32'd1);
    check("c2_spi_gnt", {31'd0, rx_ready}, 32'd0);
    @(posedge clk); #1;
    usr_req = 1'b0;
    send_byte(8'h88);
    send_byte(8'h89);
    wait_idle();
    check("c2_m21", {24'd0, mem[8'h21]}, 32'h88);
    check("c2_m22", {24'd0, mem[8'h22]}, 32'h89);
    check("c2_m41", {24'd0, mem[8'h41]}, 32'h6B);
    usr_req = 1'b1; usr_we = 1'b0; usr_addr = 8'h40;
    @(negedge clk);
    check("ur_gnt", {31'd0, usr_gnt}, 32'd1);
    check("ur_we",  {31'd0, mem_we},  32'd0);
    @(posedge clk); #1;
    usr_req = 1'b0;
    @(negedge clk);
    check("ur_rvalid", {31'd0, usr_rvalid}, 32'd1);
    check("ur_rdata",  {24'd0, usr_rdata},  32'h5A);
    @(posedge clk); #1;
`else
    // user port absent: requests are ignored, SPI burst runs unthrottled
    usr_req = 1'b1; usr_we = 1'b1; usr_addr = 8'h60; usr_wdata = 8'h99;
    base = usr_gnt_seen;
    send_cmd(8'h01, 8'h50, 8'h03);
    for (int i = 0; i < 4; i++) begin
      send_byte(8'hE0 + 8'(i));
      check("nu_no_stall", last_wait, 32'd0);
    end
    wait_idle();
    check("nu_usr_gnt", usr_gnt_seen - base, 32'd0);
    for (int i = 0; i < 4; i++) check("nu_mem", {24'd0, mem[8'h50 + i]}, 32'hE0 + i);
    check("nu_m60",       {24'd0, mem[8'h60]}, 32'h00);
    check("nu_usr_rvalid", {31'd0, usr_rvalid}, 32'd0);
    usr_req = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/spi_mem_cmd_ctrl.md
# spi_mem_cmd_ctrl

Command sequencer and arbiter between the SPI slave FIFO byte streams and a single-port synchronous BRAM. It parses addressed read/write burst commands from the SPI RX stream, drives the BRAM port, and returns read data on the SPI TX stream. It also shares the BRAM with one fabric-side user requester through alternating-priority arbitration.

## Interface
Parameters:
- ADDR_WIDTH, 8: BRAM address width; the address byte is zero-extended or truncated to this width.
- DATA_WIDTH, 8: BRAM and stream data width; fixed at 8 for the SPI side.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- rx_data  in  8  SPI RX FIFO byte
- rx_valid  in  1  RX byte available
- rx_ready  out  1  RX byte consumed on a cycle where rx_valid && rx_ready
- tx_data  out  8  byte to SPI TX FIFO
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  TX FIFO accepts; transfer on a cycle where tx_valid && tx_ready
- mem_addr  out  ADDR_WIDTH  BRAM address
- mem_we  out  1  BRAM write enable
- mem_wdata  out  8  BRAM write data
- mem_rdata  in  8  BRAM read data, valid one clk after the address is presented
- usr_req  in  1  user access request
- usr_we  in  1  user write (1) or read (0)
- usr_addr  in  ADDR_WIDTH  user address
- usr_wdata  in  8  user write data
- usr_gnt  out  1  user access performed this cycle (combinational)
- usr_rvalid  out  1  user read data valid
- usr_rdata  out  8  user read data
- busy  out  1  parser state is not IDLE

## Operation
- Command format: CMD, ADDR, LEN, then payload. LEN = n transfers n+1 bytes (1..256).
- CMD 0x01 is write; CMD 0x02 is read. Any other CMD byte is consumed and ignored; the state stays IDLE.
- States and transitions:
  - IDLE: on a valid CMD, go to ADDR.
  - ADDR: latch the pointer, go to LEN.
  - LEN: latch the count, go to WDATA or RDATA.
  - WDATA / RDATA: return to IDLE after the last byte.
- rx_ready is 1 in IDLE, ADDR, LEN and RDATA. In RDATA, RX bytes are dummy bytes and are discarded. In WDATA, rx_ready equals the SPI grant.
- WDATA: the SPI requests when rx_valid is 1. On grant, mem_we=1 and mem_addr=pointer. The pointer increments and the count decrements.
- RDATA: the SPI requests when no read is pending and tx_valid=0. On grant, the address is issued. The next cycle captures mem_rdata into tx_data and sets tx_valid=1. tx_valid stays high until tx_ready, and the count decrements on that handshake.
- Pointer arithmetic is modulo 2^ADDR_WIDTH: 0xFF+1 wraps to 0x00. Bursts that cross the top of memory wrap silently.
- Arbitration, one access per cycle:
  - When only one side requests, that side is granted.
  - When both request, the loser of the previous contested cycle wins.
  - last_winner resets to USER, so the SPI side wins the first conflict.
- User read: usr_rvalid=1 and usr_rdata=mem_rdata one cycle after usr_gnt.
- mem_addr, mem_we and mem_wdata are combinational from the granted side. When there is no grant, mem_we=0.

## Timing
- Reset values:
  - state=IDLE, busy=0, tx_valid=0, tx_data=0.
  - usr_rvalid=0, usr_rdata=0.
  - No grant, so mem_we=0 and usr_gnt=0.
  - Pointer and count are 0.
- Reset mid-burst aborts the burst. Bytes already written remain in memory. A pending read is dropped and tx_valid clears immediately.
- Read latency: grant at cycle t, tx_valid=1 at t+1.
- Minimum spacing is 2 cycles per read byte when tx_ready=1 and the SPI side is uncontended.
- Write throughput is 1 byte/cycle when uncontended.
- An RX byte arriving in the same cycle that LEN is consumed is not accepted until the next cycle (WDATA).
- A user request held under contention is granted within 2 cycles.

## Configuration
- SPI_MEM_USER_PORT_EN defined: the user port and arbiter are present as described above.
- SPI_MEM_USER_PORT_EN undefined:
  - The arbiter is removed and the SPI side is always granted.
  - usr_gnt=0, usr_rvalid=0 and usr_rdata=0 are constant.
  - usr_* inputs are ignored.

## Test plan
- Write then read back:
  - Stimulus: 01 10 03 AA BB CC DD, then 02 10 03 plus 4 dummy bytes.
  - Required: BRAM[0x10..0x13]=AA,BB,CC,DD, and the TX stream carries AA BB CC DD.
- Wrap-around:
  - Stimulus: 01 FE 02 11 22 33.
  - Required: BRAM[FE]=11, [FF]=22, [00]=33.
- Unknown command and TX backpressure:
  - Stimulus: 7F, then a read burst with tx_ready held low for 5 cycles.
  - Required: 7F is ignored. tx_valid and tx_data hold stable until tx_ready, with no byte lost or duplicated.
- Contention:
  - Stimulus: usr_req=1, usr_we=1 at address 0x40 with data 0x5A, presented in the same cycle as an SPI write byte 0x77 to 0x20.
  - Required: SPI is granted first and the user is granted the next cycle. Both bytes land in memory. The next conflict goes to the user.
- Reset mid-burst:
  - Stimulus: assert rst after 2 of 4 write bytes.
  - Required: busy=0 and state=IDLE immediately; the first two bytes are written. A new command after reset executes correctly.
- Macro undefined:
  - Stimulus: usr_req held at 1 during an SPI write burst.
  - Required: usr_gnt stays 0 and the SPI burst runs at 1 byte/cycle.
